crg_job_scheduler: RTL and testbench

Sequencing controller for the CRG core. Holds the CRG configuration (key, mode, width, batch size), allocates consecutive counter windows per job, issues the single-cycle run pulse, counts `dvld` beats into write addresses for the result RAM, and reports completion, timeout and protocol errors. Sits between UART_CTRL's register-write port and the CRG/result-RAM pair in the top level.

---
 rtl/crg_job_scheduler_pkg.sv | 28 ++
 rtl/crg_window_alloc.sv | 34 +++
 rtl/crg_job_scheduler.sv | 150 +++++++++++++++
 tb/tb_crg_job_scheduler.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crg_job_scheduler_pkg.sv
// CRG job scheduler shared types: state encoding,
// register map and error-flag bit positions.
package crg_job_scheduler_pkg;

  typedef logic [127:0] key_t;
  typedef logic [2:0]   mode_t;
  typedef logic [2:0]   width_t;
  typedef logic [31:0]  cr_cnt_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_COLLECT,
    S_DONE
  } sched_state_t;

  localparam logic [7:0] ADDR_KEY   = 8'h10;
  localparam logic [7:0] ADDR_MODE  = 8'h11;
  localparam logic [7:0] ADDR_WIDTH = 8'h12;
  localparam logic [7:0] ADDR_NCRS  = 8'h13;
  localparam logic [7:0] ADDR_CLR   = 8'h1F;

  localparam int ERR_NCRS  = 0;
  localparam int ERR_TMO   = 1;
  localparam int ERR_BUSY  = 2;
  localparam int ERR_PROTO = 3;

endpackage

// File: rtl/crg_window_alloc.sv
// Counter-window allocator: running base plus
// start/end of the most recently allocated window.
module crg_window_alloc #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             alloc_i,
  input  logic [CNT_W-1:0] n_i,
  output logic [CNT_W-1:0] start_o,
  output logic [CNT_W-1:0] end_o
);

  logic [CNT_W-1:0] base;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      base    <= '0;
      start_o <= '0;
      end_o   <= '0;
    end else begin
      if (alloc_i) begin
        start_o <= base + CNT_W'(1);
        end_o   <= base + n_i;
      end
      if (clr_i)
        base <= '0;
      else if (alloc_i)
        base <= base + n_i;
    end
  end

endmodule

// File: rtl/crg_job_scheduler.sv
// CRG job sequencer: config registers, window
// allocation, run pulse, beat collection, errors.
module crg_job_scheduler
  import crg_job_scheduler_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cfg_we_i,
  input  logic [7:0]        cfg_addr_i,
  input  logic [127:0]      cfg_data_i,
  input  logic              start_i,
  output key_t              key_o,
  output mode_t             mode_o,
  output width_t            width_o,
  output logic [CNT_W-1:0]  cnt_start_o,
  output logic [CNT_W-1:0]  cnt_end_o,
  output logic              run_o,
  input  logic              dvld_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [3:0]        err_o
);

  localparam int BW = ADDR_W + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int CW = (CNT_W > ADDR_W ? CNT_W : ADDR_W) + 1;

  sched_state_t     state;
  logic [CNT_W-1:0] n_crs;
  logic [BW-1:0]    job_len;
  logic [BW-1:0]    beat;
  logic [TW-1:0]    idle_cnt;
  logic [CW-1:0]    n_ext;
  logic [3:0]       err_set;
  logic             cfg_job;
  logic             clr;
  logic             n_ok;
  logic             go;
  logic             last_beat;
  logic             tmo;

  assign cfg_job = cfg_we_i &&
                   (cfg_addr_i == ADDR_KEY  ||
                    cfg_addr_i == ADDR_MODE ||
                    cfg_addr_i == ADDR_WIDTH ||
                    cfg_addr_i == ADDR_NCRS);
  assign clr   = cfg_we_i && cfg_addr_i == ADDR_CLR;
  assign n_ext = CW'(n_crs);
  assign n_ok  = n_ext != '0 &&
                 n_ext <= CW'(2 ** ADDR_W);
  assign go    = state == S_IDLE && start_i && n_ok;

  assign wr_en_o   = state == S_COLLECT && dvld_i;
  assign wr_addr_o = wr_en_o ? beat[ADDR_W-1:0] : '0;
  assign last_beat = (beat + BW'(1)) == job_len;
  assign tmo       = state == S_COLLECT && !dvld_i &&
                     idle_cnt == TW'(TIMEOUT - 1);

  always_comb begin
    err_set = '0;
    err_set[ERR_NCRS]  = state == S_IDLE && start_i && !n_ok;
    err_set[ERR_TMO]   = tmo;
    err_set[ERR_BUSY]  = cfg_job && busy_o;
    err_set[ERR_PROTO] = (start_i && state != S_IDLE) ||
                         (dvld_i && state != S_COLLECT);
  end

  crg_window_alloc #(
    .CNT_W(CNT_W)
  ) u_alloc (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (clr),
    .alloc_i(go),
    .n_i    (n_crs),
    .start_o(cnt_start_o),
    .end_o  (cnt_end_o)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= S_IDLE;
      key_o    <= '0;
      mode_o   <= '0;
      width_o  <= '0;
      n_crs    <= '0;
      job_len  <= '0;
      beat     <= '0;
      idle_cnt <= '0;
      run_o    <= 1'b0;
      done_o   <= 1'b0;
      busy_o   <= 1'b0;
      err_o    <= '0;
    end else begin
      run_o  <= 1'b0;
      done_o <= 1'b0;
      err_o  <= (clr ? 4'b0 : err_o) | err_set;
      // config is frozen for the duration of a job
      if (cfg_we_i && !busy_o) begin
        case (cfg_addr_i)
          ADDR_KEY:   key_o   <= cfg_data_i;
          ADDR_MODE:  mode_o  <= cfg_data_i[2:0];
          ADDR_WIDTH: width_o <= cfg_data_i[2:0];
          ADDR_NCRS:  n_crs   <= cfg_data_i[CNT_W-1:0];
          default: ;
        endcase
      end
      unique case (state)
        S_IDLE: begin
          if (go) begin
            state    <= S_LAUNCH;
            run_o    <= 1'b1;
            busy_o   <= 1'b1;
            job_len  <= BW'(n_crs);
            beat     <= '0;
            idle_cnt <= '0;
          end
        end
        S_LAUNCH: state <= S_COLLECT;
        S_COLLECT: begin
          if (dvld_i) begin
            beat     <= beat + BW'(1);
            idle_cnt <= '0;
            if (last_beat) begin
              state  <= S_DONE;
              done_o <= 1'b1;
            end
          end else if (tmo) begin
            state  <= S_IDLE;
            busy_o <= 1'b0;
          end else begin
            idle_cnt <= idle_cnt + TW'(1);
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          busy_o <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crg_job_scheduler.sv
// Directed scoreboard bench for crg_job_scheduler,
// plus a narrow-counter instance for window wrap.
module tb_crg_job_scheduler;
  import crg_job_scheduler_pkg::*;

  localparam int CNT_W   = 32;
  localparam int ADDR_W  = 8;
  localparam int TIMEOUT = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              cfg_we;
  logic [7:0]        cfg_addr;
  logic [127:0]      cfg_data;
  logic              start;
  logic              dvld;
  key_t              key_o;
  mode_t             mode_o;
  width_t            width_o;
  logic [CNT_W-1:0]  cnt_start_o;
  logic [CNT_W-1:0]  cnt_end_o;
  logic              run_o;
  logic              wr_en_o;
  logic [ADDR_W-1:0] wr_addr_o;
  logic              busy_o;
  logic              done_o;
  logic [3:0]        err_o;

  logic              rst_b;
  logic              cfg_we_b;
  logic [7:0]        cfg_addr_b;
  logic [127:0]      cfg_data_b;
  logic              start_b;
  logic              dvld_b;
  key_t              key_b;
  mode_t             mode_b;
  width_t            width_b;
  logic [7:0]        cs_b;
  logic [7:0]        ce_b;
  logic              run_b;
  logic              wr_en_b;
  logic [ADDR_W-1:0] wr_addr_b;
  logic              busy_b;
  logic              done_b;
  logic [3:0]        err_b;

  crg_job_scheduler #(
    .CNT_W(CNT_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr),
    .cfg_data_i(cfg_data), .start_i(start),
    .key_o(key_o), .mode_o(mode_o), .width_o(width_o),
    .cnt_start_o(cnt_start_o), .cnt_end_o(cnt_end_o),
    .run_o(run_o), .dvld_i(dvld),
    .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  crg_job_scheduler #(
    .CNT_W(8), .ADDR_W(ADDR_W), .TIMEOUT(16)
  ) dut_w (
    .clk_i(clk), .rst_i(rst_b),
    .cfg_we_i(cfg_we_b), .cfg_addr_i(cfg_addr_b),
    .cfg_data_i(cfg_data_b), .start_i(start_b),
    .key_o(key_b), .mode_o(mode_b), .width_o(width_b),
    .cnt_start_o(cs_b), .cnt_end_o(ce_b),
    .run_o(run_b), .dvld_i(dvld_b),
    .wr_en_o(wr_en_b), .wr_addr_o(wr_addr_b),
    .busy_o(busy_b), .done_o(done_b), .err_o(err_b)
  );

  int n_chk  = 0;
  int n_fail = 0;
  logic [ADDR_W-1:0] sb[$];

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [7:0] a,
                     input logic [127:0] d);
    cfg_we   = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    step();
    cfg_we   = 1'b0;
  endtask

  task automatic beat(input int idx);
    sb.push_back(ADDR_W'(idx));
    dvld = 1'b1;
    #1;
    if (wr_en_o)
      chk("wr_addr", wr_addr_o, sb.pop_front());
    else begin
      chk("wr_en", wr_en_o, 1);
      void'(sb.pop_front());
    end
    step();
    dvld = 1'b0;
  endtask

  task automatic run_job(input int n,
                         input logic [31:0] s,
                         input logic [31:0] e);
    cfg(ADDR_NCRS, n);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("run", run_o, 1);
    chk("busy_go", busy_o, 1);
    chk("cnt_start", cnt_start_o, s);
    chk("cnt_end", cnt_end_o, e);
    step();
    chk("run_one", run_o, 0);
    for (int i = 0; i < n; i++) begin
      if (i == n - 1) chk("done_early", done_o, 0);
      beat(i);
    end
    chk("done", done_o, 1);
    chk("busy_done", busy_o, 1);
    step();
    chk("done_one", done_o, 0);
    chk("busy_end", busy_o, 0);
  endtask

  int cyc;
  logic seen_done;

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0;
    cfg_data = '0; start = 1'b0; dvld = 1'b0;
    rst_b = 1'b1; cfg_we_b = 1'b0; cfg_addr_b = '0;
    cfg_data_b = '0; start_b = 1'b0; dvld_b = 1'b0;
    step(); step();
    rst = 1'b0; rst_b = 1'b0;
    chk("rst_busy", busy_o, 0);
    chk("rst_run", run_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_cs", cnt_start_o, 0);
    chk("rst_key", key_o, 0);

    cfg(ADDR_KEY, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
    cfg(ADDR_MODE, 5);
    cfg(ADDR_WIDTH, 3);
    chk("key", key_o,
        128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
    chk("mode", mode_o, 5);
    chk("width", width_o, 3);

    run_job(4, 1, 4);
    run_job(3, 5, 7);
    cfg(ADDR_CLR, 0);
    run_job(2, 1, 2);

    // illegal lengths must not launch
    cfg(ADDR_NCRS, 0);
    start = 1'b1; step(); start = 1'b0;
    chk("n0_run", run_o, 0);
    chk("n0_busy", busy_o, 0);
    chk("n0_err", err_o, 4'b0001);
    cfg(ADDR_CLR, 0);
    chk("clr_err", err_o, 0);
    cfg(ADDR_NCRS, 257);
    start = 1'b1; step(); start = 1'b0;
    chk("n257_run", run_o, 0);
    chk("n257_err", err_o, 4'b0001);
    cfg(ADDR_CLR, 0);
    run_job(256, 1, 256);

    cfg(ADDR_NCRS, 2);
    start = 1'b1; step(); start = 1'b0;
    chk("tmo_run", run_o, 1);
    cyc = 0;
    seen_done = 1'b0;
    while (busy_o && cyc < TIMEOUT + 20) begin
      step();
      cyc++;
      if (done_o) seen_done = 1'b1;
    end
    chk("tmo_cycles", cyc, TIMEOUT + 1);
    chk("tmo_busy", busy_o, 0);
    chk("tmo_err", err_o, 4'b0010);
    chk("tmo_nodone", seen_done, 0);

    cfg(ADDR_CLR, 0);
    cfg(ADDR_NCRS, 3);
    start = 1'b1; step(); start = 1'b0;
    chk("viol_cs", cnt_start_o, 1);
    step();
    cfg_we = 1'b1; cfg_addr = ADDR_MODE;
    cfg_data = 2; start = 1'b1;
    step();
    cfg_we = 1'b0; start = 1'b0;
    chk("viol_mode", mode_o, 5);
    chk("viol_err", err_o, 4'b1100);
    for (int i = 0; i < 3; i++) beat(i);
    chk("viol_done", done_o, 1);
    step();

    cfg(ADDR_CLR, 0);
    dvld = 1'b1; #1;
    chk("stray_wr", wr_en_o, 0);
    step(); dvld = 1'b0;
    chk("stray_err", err_o, 4'b1000);
    cfg(ADDR_CLR, 0);

    // same-cycle n_crs write and start: old length used
    cfg_we = 1'b1; cfg_addr = ADDR_NCRS;
    cfg_data = 5; start = 1'b1;
    step();
    cfg_we = 1'b0; start = 1'b0;
    chk("sim_cs", cnt_start_o, 1);
    chk("sim_ce", cnt_end_o, 3);
    step();
    for (int i = 0; i < 3; i++) beat(i);
    chk("sim_done", done_o, 1);
    step();
    start = 1'b1; step(); start = 1'b0;
    chk("sim2_cs", cnt_start_o, 4);
    chk("sim2_ce", cnt_end_o, 8);
    step();
    beat(0);
    beat(1);
    rst = 1'b1; step(); rst = 1'b0;
    chk("mrst_busy", busy_o, 0);
    chk("mrst_done", done_o, 0);
    chk("mrst_run", run_o, 0);
    chk("mrst_err", err_o, 0);
    chk("mrst_cs", cnt_start_o, 0);
    chk("mrst_ce", cnt_end_o, 0);
    chk("mrst_key", key_o, 0);
    chk("mrst_mode", mode_o, 0);
    chk("mrst_wr", wr_en_o, 0);
    step();
    chk("mrst_nodone", done_o, 0);
    run_job(2, 1, 2);
    chk("sb_empty", sb.size(), 0);

    // narrow counter instance: drive base to 0xFE
    cfg_we_b = 1'b1; cfg_addr_b = ADDR_NCRS;
    cfg_data_b = 254;
    step();
    cfg_we_b = 1'b0;
    start_b = 1'b1; step(); start_b = 1'b0;
    chk("w1_cs", cs_b, 8'h01);
    chk("w1_ce", ce_b, 8'hFE);
    step();
    dvld_b = 1'b1;
    for (int i = 0; i < 254; i++) begin
      sb.push_back(ADDR_W'(i));
      #1;
      if (i == 0 || i == 253) begin
        chk("w1_wr", wr_en_b, 1);
        chk("w1_addr", wr_addr_b, sb.pop_front());
      end else
        void'(sb.pop_front());
      step();
    end
    dvld_b = 1'b0;
    chk("w1_done", done_b, 1);
    step();
    cfg_we_b = 1'b1; cfg_data_b = 4;
    step();
    cfg_we_b = 1'b0;
    start_b = 1'b1; step(); start_b = 1'b0;
    chk("wrap_run", run_b, 1);
    chk("wrap_cs", cs_b, 8'hFF);
    chk("wrap_ce", ce_b, 8'h02);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
